// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, PSR flag indices and FSM states
// shared by the sequential ALU and its testbench.
package alu_pkg;

  localparam logic [7:0] OP_ADD    = 8'h05;
  localparam logic [7:0] OP_ADDI   = 8'h50;
  localparam logic [7:0] OP_ADDU   = 8'h06;
  localparam logic [7:0] OP_ADDUI  = 8'h60;
  localparam logic [7:0] OP_ADDC   = 8'h07;
  localparam logic [7:0] OP_ADDCI  = 8'h70;
  localparam logic [7:0] OP_ADDCU  = 8'h04;
  localparam logic [7:0] OP_ADDCUI = 8'h40;
  localparam logic [7:0] OP_SUB    = 8'h09;
  localparam logic [7:0] OP_SUBI   = 8'h90;
  localparam logic [7:0] OP_CMP    = 8'h0B;
  localparam logic [7:0] OP_CMPI   = 8'hB0;
  localparam logic [7:0] OP_CMPU   = 8'h08;
  localparam logic [7:0] OP_CMPUI  = 8'h0C;
  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_NOT    = 8'h0F;
  localparam logic [7:0] OP_LSH    = 8'h84;
  localparam logic [7:0] OP_LSHI   = 8'h80;
  localparam logic [7:0] OP_RSH    = 8'h85;
  localparam logic [7:0] OP_RSHI   = 8'h81;
  localparam logic [7:0] OP_ALSH   = 8'h86;
  localparam logic [7:0] OP_ARSH   = 8'h87;
  localparam logic [7:0] OP_MUL    = 8'h0E;

  localparam int FLAG_N = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 4;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// mul_iter: radix-2 signed shift-add multiplier,
// done is asserted in the cycle whose edge is WIDTH after start.
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mc;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mp;
  logic               last;

  assign last = (cnt == CW'(WIDTH - 1));

  // The multiplier MSB carries negative weight in two's complement.
  always_comb begin
    addend = '0;
    if (mp[0]) addend = last ? -mc : mc;
    acc_nxt = acc + addend;
  end

  assign done    = busy && last;
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      mc   <= '0;
      mp   <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      mc   <= {{WIDTH{a[WIDTH-1]}}, a};
      mp   <= b;
      acc  <= '0;
    end else if (busy) begin
      acc  <= acc_nxt;
      mc   <= mc << 1;
      mp   <= mp >> 1;
      cnt  <= cnt + CW'(1);
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered CR16-style ALU with internal PSR,
// valid/ready input and an iterative signed multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             psr_we,
  input  logic [4:0]       psr_din,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_t             state;
  logic [4:0]         psr;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;

  logic [WIDTH-1:0]   ext_s;
  logic [WIDTH-1:0]   ext_u;
  logic [WIDTH-1:0]   op_b;
  logic               cin;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic               add_v;
  logic               sub_v;
  logic               lt_s;
  logic [SW-1:0]      shamt;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_wr;
  logic               alu_ill;
  logic [4:0]         alu_psr;
  logic [4:0]         mul_psr;

  assign in_ready = (state == S_IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (opcode == OP_MUL);
  assign flags    = psr;

  generate
    if (MUL_EN) begin : g_mul
      mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_p)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_p    = '0;
    end
  endgenerate

  assign ext_s = {{(WIDTH-8){b[7]}}, b[7:0]};
  assign ext_u = {{(WIDTH-8){1'b0}}, b[7:0]};

  always_comb begin
    op_b = b;
    case (opcode)
      OP_ADDI, OP_ADDCI,
      OP_SUBI, OP_CMPI:   op_b = ext_s;
      OP_ADDUI, OP_ADDCUI,
      OP_CMPUI:           op_b = ext_u;
      default:            op_b = b;
    endcase
  end

  assign cin = psr[FLAG_C] &&
               ((opcode == OP_ADDC)  ||
                (opcode == OP_ADDCI) ||
                (opcode == OP_ADDCU) ||
                (opcode == OP_ADDCUI));

  assign add_w = {1'b0, a} + {1'b0, op_b}
               + {{WIDTH{1'b0}}, cin};
  assign sub_w = {1'b0, a} - {1'b0, op_b};
  assign add_v = (a[M] == op_b[M]) && (add_w[M] != a[M]);
  assign sub_v = (a[M] != op_b[M]) && (sub_w[M] != a[M]);
  assign lt_s  = $signed(a) < $signed(op_b);
  assign shamt = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b1;
    alu_ill = 1'b0;
    alu_psr = psr;
    case (opcode)
      OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI: begin
        alu_res         = add_w[M:0];
        alu_psr[FLAG_C] = add_w[WIDTH];
        alu_psr[FLAG_F] = add_v;
        alu_psr[FLAG_Z] = (add_w[M:0] == '0);
        alu_psr[FLAG_N] = add_w[M];
      end
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
        alu_res         = add_w[M:0];
        alu_psr[FLAG_C] = add_w[WIDTH];
        alu_psr[FLAG_Z] = (add_w[M:0] == '0);
      end
      OP_SUB, OP_SUBI: begin
        alu_res         = sub_w[M:0];
        alu_psr[FLAG_C] = sub_w[WIDTH];
        alu_psr[FLAG_F] = sub_v;
        alu_psr[FLAG_Z] = (sub_w[M:0] == '0);
        alu_psr[FLAG_N] = sub_w[M];
      end
      OP_CMP, OP_CMPI: begin
        alu_wr          = 1'b0;
        alu_psr[FLAG_Z] = (a == op_b);
        alu_psr[FLAG_L] = sub_w[WIDTH];
        alu_psr[FLAG_N] = lt_s;
      end
      OP_CMPU, OP_CMPUI: begin
        alu_wr          = 1'b0;
        alu_psr[FLAG_Z] = (a == op_b);
        alu_psr[FLAG_L] = sub_w[WIDTH];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_LSH, OP_LSHI, OP_ALSH:
        alu_res = a << shamt;
      OP_RSH, OP_RSHI:
        alu_res = a >> shamt;
      OP_ARSH:
        alu_res = WIDTH'($signed(a) >>> shamt);
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    mul_psr         = psr;
    mul_psr[FLAG_Z] = (mul_p[M:0] == '0);
    mul_psr[FLAG_N] = mul_p[M];
    mul_psr[FLAG_F] = (mul_p[2*WIDTH-1:WIDTH] != {WIDTH{mul_p[M]}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      psr       <= '0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state <= S_MUL;
            end else begin
              out_valid <= 1'b1;
              illegal   <= alu_ill;
              result_hi <= '0;
              psr       <= alu_psr;
              if (alu_wr) result <= alu_res;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            result    <= mul_p[M:0];
            result_hi <= mul_p[2*WIDTH-1:WIDTH];
            psr       <= mul_psr;
          end
        end
      endcase
      // A context restore wins over any same-cycle flag update.
      if (psr_we) psr <= psr_din;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus random checks of alu_seq
// against an integer-arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         psr_we;
  logic [4:0]   psr_din;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [4:0]   flags;
  logic         illegal;

  int n_run  = 0;
  int n_fail = 0;

  logic [15:0] m_res;
  logic [15:0] m_hi;
  logic [4:0]  m_flags;
  logic        m_ill;

  logic [7:0] ops [25] = '{
    OP_ADD, OP_ADDI, OP_ADDU, OP_ADDUI, OP_ADDC,
    OP_ADDCI, OP_ADDCU, OP_ADDCUI, OP_SUB, OP_SUBI,
    OP_CMP, OP_CMPI, OP_CMPU, OP_CMPUI, OP_AND,
    OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_LSHI,
    OP_RSH, OP_RSHI, OP_ALSH, OP_ARSH, OP_MUL
  };

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .psr_we    (psr_we),
    .psr_din   (psr_din),
    .out_valid (out_valid),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .illegal   (illegal)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int sg(input int u);
    return (u > 32767) ? u - 65536 : u;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic model(input logic [7:0] op,
                       input logic [15:0] av,
                       input logic [15:0] bv,
                       input bit we,
                       input logic [4:0] din);
    int ua, ub, sa, sb, s, ss, amt, ci, p, res;
    bit z, c, f, l, n, wr;
    {z, c, f, l, n} = m_flags;
    wr    = 1;
    res   = 0;
    m_ill = 0;
    m_hi  = 0;
    ua = int'(av);
    ub = int'(bv);
    case (op)
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI:
        ub = (bv[7:0] > 127) ? int'(bv[7:0]) + 65280
                             : int'(bv[7:0]);
      OP_ADDUI, OP_ADDCUI, OP_CMPUI:
        ub = int'(bv[7:0]);
      default: ;
    endcase
    sa  = sg(ua);
    sb  = sg(ub);
    amt = int'(bv) % 16;
    ci  = (op == OP_ADDC || op == OP_ADDCI ||
           op == OP_ADDCU || op == OP_ADDCUI) ? int'(c) : 0;
    case (op)
      OP_ADD, OP_ADDI, OP_ADDC, OP_ADDCI: begin
        s = ua + ub + ci; ss = sa + sb + ci;
        res = s % 65536;
        c = s > 65535; f = ovf(ss);
        z = res == 0; n = res > 32767;
      end
      OP_ADDU, OP_ADDUI, OP_ADDCU, OP_ADDCUI: begin
        s = ua + ub + ci;
        res = s % 65536;
        c = s > 65535; z = res == 0;
      end
      OP_SUB, OP_SUBI: begin
        res = (ua - ub + 65536) % 65536;
        c = ua < ub; f = ovf(sa - sb);
        z = res == 0; n = res > 32767;
      end
      OP_CMP, OP_CMPI: begin
        wr = 0; z = ua == ub; l = ua < ub; n = sa < sb;
      end
      OP_CMPU, OP_CMPUI: begin
        wr = 0; z = ua == ub; l = ua < ub;
      end
      OP_AND: res = ua & ub;
      OP_OR:  res = ua | ub;
      OP_XOR: res = ua ^ ub;
      OP_NOT: res = 65535 - ua;
      OP_LSH, OP_LSHI, OP_ALSH: res = (ua << amt) & 'hFFFF;
      OP_RSH, OP_RSHI: res = ua >> amt;
      OP_ARSH: res = (sa >>> amt) & 'hFFFF;
      OP_MUL: begin
        p = sa * sb;
        res  = p & 'hFFFF;
        m_hi = 16'((p >>> 16) & 'hFFFF);
        f = ovf(p); z = res == 0; n = res > 32767;
      end
      default: begin
        res = 0; m_ill = 1;
      end
    endcase
    if (wr) m_res = 16'(res);
    m_flags = we ? din : {z, c, f, l, n};
  endtask

  task automatic do_op(input logic [7:0] op,
                       input logic [15:0] av,
                       input logic [15:0] bv,
                       input bit we = 0,
                       input logic [4:0] din = '0);
    int n;
    int rdy_low;
    @(negedge clk);
    opcode   = op;
    a        = av;
    b        = bv;
    psr_we   = we;
    psr_din  = din;
    in_valid = 1'b1;
    check("ready", 32'(in_ready), 32'd1);
    model(op, av, bv, we, din);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    psr_we   = 1'b0;
    if (op == OP_MUL) begin
      n = 0;
      rdy_low = 0;
      while (!out_valid && n < W + 4) begin
        if (!in_ready) rdy_low++;
        @(posedge clk);
        #1;
        n++;
      end
      check("mul_lat", 32'(n), 32'(W));
      check("mul_rdy_low", 32'(rdy_low), 32'(W));
      check("mul_rdy_back", 32'(in_ready), 32'd1);
    end
    check("ov", 32'(out_valid), 32'd1);
    check("res", 32'(result), 32'(m_res));
    check("hi", 32'(result_hi), 32'(m_hi));
    check("flg", 32'(flags), 32'(m_flags));
    check("ill", 32'(illegal), 32'(m_ill));
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0]  rop;
    bit          rwe;
    int          seen;

    reset    = 1'b1;
    in_valid = 1'b0;
    opcode   = '0;
    a        = '0;
    b        = '0;
    psr_we   = 1'b0;
    psr_din  = '0;
    m_res    = '0;
    m_hi     = '0;
    m_flags  = '0;
    m_ill    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_hi", 32'(result_hi), 32'd0);
    check("rst_flg", 32'(flags), 32'd0);
    check("rst_ill", 32'(illegal), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);

    // signed overflow into the sign bit
    do_op(OP_ADD, 16'h7FFF, 16'h0001);
    check("add_flg", 32'(flags), 32'b00101);
    check("add_res", 32'(result), 32'h8000);

    // carry chained into a back-to-back ADDC
    do_op(OP_ADDU, 16'hFFFF, 16'h0001);
    check("addu_flg", 32'(flags & 5'b11000), 32'b11000);
    do_op(OP_ADDC, 16'h0000, 16'h0000);
    check("addc_res", 32'(result), 32'd1);
    check("addc_c", 32'(flags[3]), 32'd0);

    do_op(OP_CMP, 16'hFFFB, 16'h0003);
    check("cmp_res", 32'(result), 32'd1);
    check("cmp_nlz", 32'({flags[4], flags[1], flags[0]}),
          32'b001);
    do_op(OP_CMPU, 16'hFFFB, 16'h0003);
    check("cmpu_nl", 32'({flags[1], flags[0]}), 32'b01);

    do_op(OP_MUL, 16'hFFFD, 16'h0007);
    check("mul_prod", {result_hi, result}, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    check("mul_pulse", 32'(out_valid), 32'd0);

    // reset during the multiply iterations
    @(negedge clk);
    opcode   = OP_MUL;
    a        = 16'h1234;
    b        = 16'h5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_ready", 32'(in_ready), 32'd0);
    check("mrst_flg", 32'(flags), 32'd0);
    check("mrst_res", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_res   = '0;
    m_hi    = '0;
    m_flags = '0;
    @(posedge clk);
    #1;
    check("mrst_rel", 32'(in_ready), 32'd1);
    repeat (W + 2) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("mrst_noov", 32'(seen), 32'd0);

    do_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 5'b10000);
    check("psrwe_flg", 32'(flags), 32'b10000);
    do_op(OP_ARSH, 16'h8000, 16'd15);
    check("arsh_res", 32'(result), 32'hFFFF);
    do_op(OP_LSH, 16'h0001, 16'd20);
    check("lsh_res", 32'(result), 32'h0010);
    do_op(8'hFF, 16'h1234, 16'h5678);
    check("illop", 32'(illegal), 32'd1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rop = 8'($urandom);
      else rop = ops[$urandom_range(0, 24)];
      rwe = ($urandom_range(0, 15) == 0) && (rop != OP_MUL);
      do_op(rop, rnd16(), rnd16(), rwe, 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 16-bit combinational ALU. It executes the same CR16-style opcode set at any `WIDTH` and owns the processor status register (PSR) flags internally. `ADDC`-family carry-in is therefore taken from the stored C flag rather than an input pin. It adds an iterative signed `MUL` and a valid/ready input handshake, and sits between the register-file read stage and writeback in the datapath.

## Interface
- `WIDTH`, 16: operand/result width, ≥ 8.
- `MUL_EN`, 1: 1 = MUL implemented; 0 = MUL opcode is illegal.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset (decided: one clock, sync active-high reset).
- `in_valid`  in  1: request present.
- `in_ready`  out  1: block can accept a request.
- `opcode`  in  8: ISA opcode.
- `a`, `b`  in  WIDTH each: operands. `I` opcodes use `b[7:0]` only.
- `psr_we`  in  1: load PSR from `psr_din` (context restore).
- `psr_din`  in  5: PSR load value.
- `out_valid`  out  1: one-cycle pulse; result/flags updated.
- `result`  out  WIDTH: registered result (low half for MUL).
- `result_hi`  out  WIDTH: MUL high half; 0 after every non-MUL op.
- `flags`  out  5: PSR bits {Z,C,F,L,N} = bits [4:0].
- `illegal`  out  1: pulse with `out_valid` for an undefined opcode.

## Operation
- Accept occurs when `in_valid && in_ready`. All single-cycle ops are computed combinationally from `a`, `b`, `opcode` and the current PSR, and registered at the accept edge.
- Opcodes (hex):
  - Add family: ADD 05, ADDI 50, ADDU 06, ADDUI 60, ADDC 07, ADDCI 70, ADDCU 04, ADDCUI 40.
  - Subtract/compare: SUB 09, SUBI 90, CMP 0B, CMPI B0, CMPU 08, CMPUI 0C.
  - Logic: AND 01, OR 02, XOR 03, NOT 0F (~a).
  - Shifts: LSH 84, LSHI 80, RSH 85, RSHI 81, ALSH 86, ARSH 87.
  - MUL 0E.
- Immediate extension:
  - ADDI, ADDCI, SUBI, CMPI sign-extend `b[7:0]`.
  - ADDUI, ADDCUI, CMPUI zero-extend `b[7:0]`.
- Shift amount is `b[$clog2(WIDTH)-1:0]`; upper bits are ignored. ALSH equals LSH. ARSH replicates the MSB.
- Carry-in is the current PSR C for ADDC, ADDCI, ADDCU and ADDCUI.
- Flag updates (bits not listed are held):
  - Signed add: C = carry-out, F = signed overflow, Z, N = result MSB.
  - Unsigned add: C, Z only.
  - SUB/SUBI: C = borrow (a <u b), F, Z, N.
  - CMP/CMPI: Z = (a==b), L = a <u b, N = a <s b. `result` is held.
  - CMPU/CMPUI: Z, L only. `result` is held.
  - Logic and shift ops: no flag change.
  - MUL: Z and N on the low half; F = 1 if the high half is not the sign extension of the low half.
- MUL is a signed WIDTH×WIDTH → 2·WIDTH product, computed iteratively.
- Undefined opcode: accepted, `result` = 0, `illegal` = 1, flags held.
- `psr_we` loads the PSR. It overrides any ALU flag update in the same cycle.
- FSM:
  - IDLE: accepting. Moves to MUL_BUSY when MUL is accepted.
  - MUL_BUSY: counts WIDTH iterations, then returns to IDLE.

## Timing
- Reset values: `in_ready` 0 while `reset` is high, 1 on the first cycle after. `out_valid` 0, `illegal` 0, `result` 0, `result_hi` 0, `flags` 00000, FSM IDLE.
- Single-cycle op accepted at edge k: `out_valid`, `result` and `flags` are valid after edge k. Back-to-back accepts are allowed every cycle.
- A dependent ADDC accepted at edge k+1 sees the C flag written at edge k. No stall is needed.
- MUL accepted at edge k:
  - `in_ready` is low from after edge k until `out_valid`.
  - `out_valid` is high after edge k+WIDTH.
  - `in_ready` is 1 in that same cycle, so the next op may be accepted at edge k+WIDTH+1.
- Reset mid-MUL: the operation is aborted, no `out_valid` is produced, and all outputs take their reset values.

## Structure
- `alu_pkg` holds:
  - the opcode localparams;
  - the flag index constants FLAG_N=0, FLAG_L=1, FLAG_F=2, FLAG_C=3, FLAG_Z=4;
  - the FSM state typedef.
- Sub-module `mul_iter` (parameter `WIDTH`): start/done handshake, radix-2 signed shift-add, done exactly WIDTH cycles after start. Only instantiated when `MUL_EN`=1.

## Test plan (WIDTH=16)
- ADD 32767+1 → `result` 0x8000, `flags` 00101 (F, N), `out_valid` one cycle after accept.
- ADDU 0xFFFF+1 → `result` 0, Z=1, C=1. The next cycle, ADDC 0+0 → `result` 1, C=0, Z=0.
- CMP a=−5, b=3 → N=1, L=0, Z=0, `result` unchanged. CMPU with the same operands → L=0, N is held.
- MUL −3×7 → {`result_hi`,`result`} = 0xFFFF_FFEB, F=0, N=1. `in_ready` is low for 16 cycles and `out_valid` arrives at cycle 16.
- Reset asserted during MUL iteration 5 → no `out_valid`, `flags` 0, `in_ready` 1 on the first cycle after release.
- `psr_we` with `psr_din`=10000 coincident with an ADD accept producing a carry → `flags` = 10000. ARSH 0x8000 by b=15 → 0xFFFF. LSH 0x0001 by b=20 → 0x0010.
